ptp_bus_arbiter: RTL and testbench

Two-master arbiter for the 32-bit on-chip register bus of the PTPv2 core. It lets the host CPU port and an internal requester, such as a timestamp auto-fetch engine, share one `bus2ip_*` access path into the RTC and timestamp units. Arbitration is round-robin. Each transaction is a single read or write with a req/ack handshake. The block sits directly in front of the core's bus port, in the bus clock domain.

---
 rtl/ptp_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_ptp_bus_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptp_bus_arbiter.sv
// Round-robin arbiter letting two masters share the PTPv2 core register bus.
// One single-beat read or write is in flight at a time; every output is registered.
module ptp_bus_arbiter #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        bus2ip_clk,
    input  logic        bus2ip_rst,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_rdata_o,

    output logic [31:0] bus2ip_addr_o,
    output logic [31:0] bus2ip_data_o,
    output logic        bus2ip_rd_ce_o,
    output logic        bus2ip_wr_ce_o,
    input  logic [31:0] ip2bus_data_i,

    output logic        busy_o,
    output logic        gnt_id_o
);

    typedef enum logic [1:0] {StIdle, StCe, StWait, StAck} state_e;

    // WAIT runs RD_LAT-1 extra cycles after the CE cycle; unused when RD_LAT is 0.
    localparam int unsigned LatLoad = (RD_LAT > 0) ? RD_LAT - 1 : 0;

    state_e      r_state;
    logic        r_prio;
    logic        r_gnt;
    logic        r_we;
    logic        r_rd_ce;
    logic        r_wr_ce;
    logic        r_m0_ack;
    logic        r_m1_ack;
    logic        r_busy;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;

    logic        w_any_req;
    logic        w_pick;
    logic        w_pick_we;
    logic [31:0] w_pick_addr;
    logic [31:0] w_pick_wdata;

    assign w_any_req    = m0_req_i | m1_req_i;
    // r_prio names the master that wins a tie; a lone requester always wins.
    assign w_pick       = (m0_req_i & m1_req_i) ? r_prio : m1_req_i;
    assign w_pick_we    = w_pick ? m1_we_i    : m0_we_i;
    assign w_pick_addr  = w_pick ? m1_addr_i  : m0_addr_i;
    assign w_pick_wdata = w_pick ? m1_wdata_i : m0_wdata_i;

    always_ff @(posedge bus2ip_clk or posedge bus2ip_rst) begin
        if (bus2ip_rst) begin
            r_state    <= StIdle;
            r_prio     <= 1'b0;
            r_gnt      <= 1'b0;
            r_we       <= 1'b0;
            r_rd_ce    <= 1'b0;
            r_wr_ce    <= 1'b0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= 3'd0;
            r_addr     <= 32'd0;
            r_data     <= 32'd0;
            r_m0_rdata <= 32'd0;
            r_m1_rdata <= 32'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_state <= StCe;
                        r_gnt   <= w_pick;
                        r_prio  <= ~w_pick;
                        r_we    <= w_pick_we;
                        r_addr  <= w_pick_addr;
                        r_data  <= w_pick_wdata;
                        r_rd_ce <= ~w_pick_we;
                        r_wr_ce <= w_pick_we;
                        r_busy  <= 1'b1;
                    end
                end
                StCe: begin
                    r_rd_ce <= 1'b0;
                    r_wr_ce <= 1'b0;
                    if (r_we || (RD_LAT == 0)) begin
                        if (!r_we) begin
                            if (r_gnt) r_m1_rdata <= ip2bus_data_i;
                            else       r_m0_rdata <= ip2bus_data_i;
                        end
                        r_m0_ack <= ~r_gnt;
                        r_m1_ack <= r_gnt;
                        r_state  <= StAck;
                    end else begin
                        r_cnt   <= 3'(LatLoad);
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (r_cnt == 3'd0) begin
                        if (r_gnt) r_m1_rdata <= ip2bus_data_i;
                        else       r_m0_rdata <= ip2bus_data_i;
                        r_m0_ack <= ~r_gnt;
                        r_m1_ack <= r_gnt;
                        r_state  <= StAck;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                StAck: begin
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign m0_ack_o       = r_m0_ack;
    assign m1_ack_o       = r_m1_ack;
    assign m0_rdata_o     = r_m0_rdata;
    assign m1_rdata_o     = r_m1_rdata;
    assign bus2ip_addr_o  = r_addr;
    assign bus2ip_data_o  = r_data;
    assign bus2ip_rd_ce_o = r_rd_ce;
    assign bus2ip_wr_ce_o = r_wr_ce;
    assign busy_o         = r_busy;
    assign gnt_id_o       = r_gnt;

`ifndef SYNTHESIS
    a_ce_excl: assert property (@(posedge bus2ip_clk) disable iff (bus2ip_rst)
        !(r_rd_ce && r_wr_ce));
    a_ce_pulse: assert property (@(posedge bus2ip_clk) disable iff (bus2ip_rst)
        (r_rd_ce || r_wr_ce) |=> !(r_rd_ce || r_wr_ce));
    a_ack_excl: assert property (@(posedge bus2ip_clk) disable iff (bus2ip_rst)
        !(r_m0_ack && r_m1_ack));
    a_ack_pulse: assert property (@(posedge bus2ip_clk) disable iff (bus2ip_rst)
        (r_m0_ack || r_m1_ack) |=> !(r_m0_ack || r_m1_ack));
`endif

endmodule

// File: tb/tb_ptp_bus_arbiter.sv
// Directed bench for ptp_bus_arbiter: three instances with RD_LAT 1, 0 and 7 share
// one clock and reset; a small core model returns address-tagged data at the exact latency.
module tb_ptp_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        m0_req [3];
    logic        m0_we [3];
    logic [31:0] m0_addr [3];
    logic [31:0] m0_wdata [3];
    logic        m0_ack [3];
    logic [31:0] m0_rdata [3];
    logic        m1_req [3];
    logic        m1_we [3];
    logic [31:0] m1_addr [3];
    logic [31:0] m1_wdata [3];
    logic        m1_ack [3];
    logic [31:0] m1_rdata [3];
    logic [31:0] b_addr [3];
    logic [31:0] b_data [3];
    logic        rd_ce [3];
    logic        wr_ce [3];
    logic [31:0] ip_data [3];
    logic        busy [3];
    logic        gnt [3];
    logic [7:0]  hist [3];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ptp_bus_arbiter #(
            .RD_LAT((g == 0) ? 1 : ((g == 1) ? 0 : 7))
        ) u_dut (
            .bus2ip_clk     (clk),
            .bus2ip_rst     (rst),
            .m0_req_i       (m0_req[g]),
            .m0_we_i        (m0_we[g]),
            .m0_addr_i      (m0_addr[g]),
            .m0_wdata_i     (m0_wdata[g]),
            .m0_ack_o       (m0_ack[g]),
            .m0_rdata_o     (m0_rdata[g]),
            .m1_req_i       (m1_req[g]),
            .m1_we_i        (m1_we[g]),
            .m1_addr_i      (m1_addr[g]),
            .m1_wdata_i     (m1_wdata[g]),
            .m1_ack_o       (m1_ack[g]),
            .m1_rdata_o     (m1_rdata[g]),
            .bus2ip_addr_o  (b_addr[g]),
            .bus2ip_data_o  (b_data[g]),
            .bus2ip_rd_ce_o (rd_ce[g]),
            .bus2ip_wr_ce_o (wr_ce[g]),
            .ip2bus_data_i  (ip_data[g]),
            .busy_o         (busy[g]),
            .gnt_id_o       (gnt[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 7);
    endfunction

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    // Core model: data is only valid exactly RD_LAT cycles after the rd_ce cycle.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) hist[k] <= rst ? 8'h00 : {hist[k][6:0], rd_ce[k]};
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            logic [2:0] li;
            logic       vld;
            li  = 3'(lat_of(k) - 1);
            vld = (lat_of(k) == 0) ? rd_ce[k] : hist[k][li];
            ip_data[k] = vld ? tag(b_addr[k]) : 32'hBAD0_BAD0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            m0_req[k] = 1'b0; m0_we[k] = 1'b0; m0_addr[k] = '0; m0_wdata[k] = '0;
            m1_req[k] = 1'b0; m1_we[k] = 1'b0; m1_addr[k] = '0; m1_wdata[k] = '0;
        end
        #1 rst = 1'b1;
        tick;
        tick;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({m0_ack[k], m1_ack[k], rd_ce[k], wr_ce[k], busy[k], gnt[k]} !== 6'b0) begin
                errors++;
                $display("FAIL reset_ctrl inst %0d got %b%b%b%b%b%b required 000000", k,
                         m0_ack[k], m1_ack[k], rd_ce[k], wr_ce[k], busy[k], gnt[k]);
            end
            checks++;
            if ({b_addr[k], b_data[k], m0_rdata[k], m1_rdata[k]} !== 128'b0) begin
                errors++;
                $display("FAIL reset_data inst %0d got %h %h %h %h required zeros", k,
                         b_addr[k], b_data[k], m0_rdata[k], m1_rdata[k]);
            end
        end
        rst = 1'b0;
        tick;
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b required 0", busy[0]);
        end
    endtask

    task automatic test_write;
        m0_req[0] = 1'b1; m0_we[0] = 1'b1;
        m0_addr[0] = 32'h0000_0104; m0_wdata[0] = 32'hDEAD_BEEF;
        tick;
        checks++;
        if ({wr_ce[0], rd_ce[0], busy[0], gnt[0], m0_ack[0]} !== 5'b10100) begin
            errors++;
            $display("FAIL write_ce got wr=%b rd=%b busy=%b gnt=%b ack=%b required 1 0 1 0 0",
                     wr_ce[0], rd_ce[0], busy[0], gnt[0], m0_ack[0]);
        end
        checks++;
        if ({b_addr[0], b_data[0]} !== {32'h0000_0104, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL write_bus got addr=%h data=%h required 00000104 deadbeef",
                     b_addr[0], b_data[0]);
        end
        tick;
        checks++;
        if ({m0_ack[0], m1_ack[0], wr_ce[0]} !== 3'b100) begin
            errors++;
            $display("FAIL write_ack got m0=%b m1=%b wr=%b required 1 0 0",
                     m0_ack[0], m1_ack[0], wr_ce[0]);
        end
        m0_req[0] = 1'b0;
        tick;
        checks++;
        if ({m0_ack[0], m1_ack[0], busy[0]} !== 3'b000) begin
            errors++;
            $display("FAIL write_done got m0=%b m1=%b busy=%b required 0 0 0",
                     m0_ack[0], m1_ack[0], busy[0]);
        end
    endtask

    task automatic test_read(input int k, input logic m, input logic [31:0] addr,
                             input logic [31:0] other_exp);
        int          n;
        logic        ack_v;
        logic [31:0] rd_v;
        logic [31:0] oth_v;
        if (m) begin
            m1_req[k] = 1'b1; m1_we[k] = 1'b0; m1_addr[k] = addr;
        end else begin
            m0_req[k] = 1'b1; m0_we[k] = 1'b0; m0_addr[k] = addr;
        end
        tick;
        n = 1;
        checks++;
        if ({rd_ce[k], wr_ce[k], gnt[k], b_addr[k]} !== {1'b1, 1'b0, m, addr}) begin
            errors++;
            $display("FAIL read_ce inst %0d got rd=%b wr=%b gnt=%b addr=%h required 1 0 %b %h",
                     k, rd_ce[k], wr_ce[k], gnt[k], b_addr[k], m, addr);
        end
        ack_v = m ? m1_ack[k] : m0_ack[k];
        while (!ack_v && n < 20) begin
            tick;
            n++;
            ack_v = m ? m1_ack[k] : m0_ack[k];
        end
        checks++;
        if (n != lat_of(k) + 2) begin
            errors++;
            $display("FAIL read_ack_cycle inst %0d got t+%0d required t+%0d", k, n, lat_of(k) + 2);
        end
        rd_v  = m ? m1_rdata[k] : m0_rdata[k];
        oth_v = m ? m0_rdata[k] : m1_rdata[k];
        checks++;
        if (rd_v !== tag(addr)) begin
            errors++;
            $display("FAIL read_data inst %0d got %h required %h", k, rd_v, tag(addr));
        end
        checks++;
        if (oth_v !== other_exp) begin
            errors++;
            $display("FAIL read_other inst %0d got %h required %h", k, oth_v, other_exp);
        end
        m0_req[k] = 1'b0;
        m1_req[k] = 1'b0;
        tick;
    endtask

    task automatic test_m1_read;
        test_read(0, 1'b0, 32'h0000_0020, 32'h0);
        test_read(0, 1'b1, 32'h0000_0000, tag(32'h0000_0020));
    endtask

    task automatic test_round_robin;
        int   n;
        logic em;
        do_reset;
        m0_req[0] = 1'b1; m0_we[0] = 1'b0; m0_addr[0] = 32'h0000_0040;
        m1_req[0] = 1'b1; m1_we[0] = 1'b0; m1_addr[0] = 32'h0000_0080;
        for (int j = 0; j < 4; j++) begin
            em = (j % 2 == 1);
            n  = 0;
            do begin
                tick;
                n++;
            end while (!(m0_ack[0] || m1_ack[0]) && n < 20);
            checks++;
            if (n != ((j == 0) ? 3 : 4)) begin
                errors++;
                $display("FAIL rr_spacing txn %0d got %0d cycles required %0d", j, n,
                         (j == 0) ? 3 : 4);
            end
            checks++;
            if ({m0_ack[0], m1_ack[0], gnt[0]} !== {~em, em, em}) begin
                errors++;
                $display("FAIL rr_grant txn %0d got m0=%b m1=%b gnt=%b required %b %b %b", j,
                         m0_ack[0], m1_ack[0], gnt[0], ~em, em, em);
            end
            checks++;
            if ((em ? m1_rdata[0] : m0_rdata[0]) !== tag(em ? 32'h80 : 32'h40)) begin
                errors++;
                $display("FAIL rr_data txn %0d got %h required %h", j,
                         em ? m1_rdata[0] : m0_rdata[0], tag(em ? 32'h80 : 32'h40));
            end
        end
        m0_req[0] = 1'b0;
        m1_req[0] = 1'b0;
        tick;
    endtask

    task automatic test_latency_sweep;
        test_read(1, 1'b0, 32'h0000_0300, 32'h0);
        test_read(2, 1'b1, 32'h0000_0700, 32'h0);
    endtask

    task automatic test_reset_mid;
        logic seen;
        m0_req[2] = 1'b1; m0_we[2] = 1'b0; m0_addr[2] = 32'h0000_0010;
        tick;
        tick;
        tick;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rd_ce[2], wr_ce[2], m0_ack[2], m1_ack[2], busy[2]} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_async got rd=%b wr=%b a0=%b a1=%b busy=%b required 0",
                     rd_ce[2], wr_ce[2], m0_ack[2], m1_ack[2], busy[2]);
        end
        m0_req[2] = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (m0_ack[2] || m1_ack[2] || busy[2]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_noack got activity=%b required 0", seen);
        end
        test_read(2, 1'b1, 32'h0000_0024, 32'h0);
    endtask

    task automatic test_back_to_back;
        logic ec;
        logic ea;
        m0_req[0] = 1'b1; m0_we[0] = 1'b1;
        m0_addr[0] = 32'h0000_0200; m0_wdata[0] = 32'hCAFE_0001;
        for (int n = 1; n <= 7; n++) begin
            tick;
            ec = (n == 1) || (n == 4);
            ea = (n == 2) || (n == 5);
            checks++;
            if ({wr_ce[0], rd_ce[0], m0_ack[0], m1_ack[0]} !== {ec, 1'b0, ea, 1'b0}) begin
                errors++;
                $display("FAIL b2b cycle t+%0d got wr=%b rd=%b a0=%b a1=%b required %b 0 %b 0",
                         n, wr_ce[0], rd_ce[0], m0_ack[0], m1_ack[0], ec, ea);
            end
            if (n == 5) m0_req[0] = 1'b0;
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_m1_read;
        test_round_robin;
        test_latency_sweep;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
